// File: rtl/panel_switch_reader.sv
// Front-panel switch reader: synchronises and debounces active-low switches, keeps sticky change
// flags and returns either register over a single-cycle read handshake. Optional irq: PANEL_SWITCH_READER_IRQ_EN.
module panel_switch_reader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_n,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             bus_oe,
  output logic [WIDTH-1:0] state
`ifdef PANEL_SWITCH_READER_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $fatal(1, "panel_switch_reader: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0]            state_n;
  logic [WIDTH-1:0]            changed;
  logic [WIDTH-1:0]            changed_n;
  logic [WIDTH-1:0]            set_mask;
  logic [WIDTH-1:0]            clr_mask;

  always_comb begin
    cnt_n    = cnt;
    state_n  = state;
    set_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == state[i]) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        state_n[i]  = ~state[i];
        cnt_n[i]    = '0;
        set_mask[i] = 1'b1;
      end else begin
        cnt_n[i] = cnt[i] + CNT_W'(1);
      end
    end
    // a read clears only what it returns; a set on the same edge wins so no event is lost
    clr_mask  = (rd_req && rd_sel) ? changed : '0;
    changed_n = (changed & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      cnt      <= '0;
      state    <= '0;
      changed  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      sync1    <= ~sw_n;
      sync2    <= sync1;
      cnt      <= cnt_n;
      state    <= state_n;
      changed  <= changed_n;
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_sel ? changed : state;
      end else begin
        rd_data <= '0;
      end
    end
  end

  assign bus_oe = rd_valid;

`ifdef PANEL_SWITCH_READER_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |changed;
    end
  end
`endif

endmodule

// File: tb/tb_panel_switch_reader.sv
// Directed bench for panel_switch_reader: reset, debounce latency, glitch rejection,
// back-to-back reads, set-vs-clear collision and mid-debounce reset.
module tb_panel_switch_reader;

  localparam int WIDTH = 8;
  localparam int DEB   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_n;
  logic             rd_req;
  logic             rd_sel;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             bus_oe;
  logic [WIDTH-1:0] state;
`ifdef PANEL_SWITCH_READER_IRQ_EN
  logic             irq;
`endif

  int errors = 0;
  int checks = 0;

  panel_switch_reader #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_n     (sw_n),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .bus_oe   (bus_oe),
    .state    (state)
`ifdef PANEL_SWITCH_READER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic sel, input logic [WIDTH-1:0] exp, input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_oe"}, 32'(bus_oe), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int bad;
    rst    = 1'b1;
    sw_n   = 8'hFF;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_oe", 32'(bus_oe), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(state), 32'd0);
`ifdef PANEL_SWITCH_READER_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    // idle after reset
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_valid !== 1'b0 || state !== 8'h00) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    do_read(1'b1, 8'h00, "idle_changed");
    tick();
    check("idle_data_zero", 32'(rd_data), 32'd0);

    // clean press of bit 3: sampled at edge k, visible after edge k+17
    sw_n = 8'hF7;
    bad  = 0;
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      if (state !== 8'h00) bad++;
    end
    check("press_early", 32'(bad), 32'd0);
    tick();
    check("press_state", 32'(state), 32'h08);
    do_read(1'b1, 8'h08, "press_chg1");
    do_read(1'b1, 8'h00, "press_chg2");
    do_read(1'b0, 8'h08, "press_st");

    sw_n = 8'hFF;
    for (int i = 0; i < DEB + 4; i++) tick();
    check("release_state", 32'(state), 32'h00);
    do_read(1'b1, 8'h08, "release_chg");

    // glitch train on bit 0: 15 low, 1 high, 15 low
    bad = 0;
    sw_n = 8'hFE;
    for (int i = 0; i < 15; i++) begin tick(); if (state !== 8'h00) bad++; end
    sw_n = 8'hFF;
    tick();
    if (state !== 8'h00) bad++;
    sw_n = 8'hFE;
    for (int i = 0; i < 15; i++) begin tick(); if (state !== 8'h00) bad++; end
    sw_n = 8'hFF;
    for (int i = 0; i < DEB + 4; i++) begin tick(); if (state !== 8'h00) bad++; end
    check("glitch_state", 32'(bad), 32'd0);
    do_read(1'b1, 8'h00, "glitch_chg");

    // build state=A5, changed=81
    sw_n = 8'hDB;
    for (int i = 0; i < DEB + 4; i++) tick();
    check("st24", 32'(state), 32'h24);
    do_read(1'b1, 8'h24, "chg24");
    sw_n = 8'h5A;
    for (int i = 0; i < DEB + 4; i++) tick();
    check("stA5", 32'(state), 32'hA5);

    // back-to-back reads
    rd_req = 1'b1;
    rd_sel = 1'b0;
    tick();
    check("b2b0_valid", 32'(rd_valid), 32'd1);
    check("b2b0_data", 32'(rd_data), 32'hA5);
    rd_sel = 1'b1;
    tick();
    check("b2b1_valid", 32'(rd_valid), 32'd1);
    check("b2b1_oe", 32'(bus_oe), 32'd1);
    check("b2b1_data", 32'(rd_data), 32'h81);
    rd_sel = 1'b0;
    tick();
    check("b2b2_valid", 32'(rd_valid), 32'd1);
    check("b2b2_data", 32'(rd_data), 32'hA5);
    rd_req = 1'b0;
    tick();
    check("b2b_end_valid", 32'(rd_valid), 32'd0);
    check("b2b_end_oe", 32'(bus_oe), 32'd0);
    check("b2b_end_data", 32'(rd_data), 32'h00);
    do_read(1'b1, 8'h00, "b2b_cleared");

    // bit 0 release -> changed=01, state=A4
    sw_n = 8'h5B;
    for (int i = 0; i < DEB + 4; i++) tick();
    check("stA4", 32'(state), 32'hA4);
    // release bit 5 and read changed on the very edge its debounce completes
    sw_n = 8'h7B;
    for (int i = 0; i < DEB + 1; i++) tick();
    check("coll_before", 32'(state), 32'hA4);
    do_read(1'b1, 8'h01, "coll_rd1");
    check("coll_state", 32'(state), 32'h84);
    do_read(1'b1, 8'h20, "coll_rd2");
    do_read(1'b1, 8'h00, "coll_rd3");

    // reset mid-debounce with bit 2 held
    sw_n = 8'hFF;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_state", 32'(state), 32'h00);
    sw_n = 8'hFB;
    for (int i = 0; i < 12; i++) tick();
    check("mid_state", 32'(state), 32'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(state), 32'h00);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      if (state !== 8'h00) bad++;
    end
    check("rdeb_early", 32'(bad), 32'd0);
    tick();
    check("rdeb_state", 32'(state), 32'h04);
`ifdef PANEL_SWITCH_READER_IRQ_EN
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    do_read(1'b1, 8'h04, "irq_rd");
    check("irq_hold", 32'(irq), 32'd1);
    tick();
    check("irq_fall", 32'(irq), 32'd0);
`else
    do_read(1'b1, 8'h04, "rdeb_chg");
`endif
    do_read(1'b1, 8'h00, "final_chg");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
